mprf_regfile: RTL
=================

// Module: mprf_regfile
// PURPOSE
//  Parametrised multi-port GPR file with write-back forwarding, register scoreboard and reset-sweep init.
//  Serves ID-stage operand read for an NWR-issue pipeline; write ports come from WB, set ports from issue.
//  Later write port = younger instruction, so higher write-port index has forwarding/commit priority.
// PARAMETERS
//  DATA_W  32  register width in bits
//  NREG    32  number of architectural registers (power of 2, >=4); r0 hardwired to zero
//  NRD     4   number of combinational read ports
//  NWR     2   number of write ports (= number of scoreboard set ports)
// PORTS
//  clk       in   1            clock; all state on posedge
//  rst       in   1            asynchronous, active-low reset
//  init_done out  1            1 once init sweep completes; stays 1 until next reset
//  raddr     in   NRD*AW       read addresses (AW = $clog2(NREG))
//  rdata     out  NRD*DATA_W   read data, combinational, with write-forwarding
//  rbusy     out  NRD          read register has pending producer (scoreboard)
//  wen       in   NWR          write enables (WB)
//  waddr     in   NWR*AW       write addresses
//  wdata     in   NWR*DATA_W   write data
//  set_en    in   NWR          mark destination busy (issue)
//  set_addr  in   NWR*AW       destination to mark busy
//  flush     in   1            clear all busy bits (pipeline flush)
// BEHAVIOUR
//  Reset: init_done=0, all busy=0, sweep counter=1, FSM=INIT; array not reset asynchronously.
//  FSM INIT: one register per cycle, rf[cnt]<=0, cnt 1..NREG-1; after writing NREG-1 -> RUN, init_done=1
//   next cycle (NREG-1 cycles after rst deasserts). In INIT: wen/set_en/flush ignored, rdata=0, rbusy=0.
//  rst asserted mid-sweep or in RUN: immediate return to INIT, counter=1, busy cleared.
//  Read (RUN): raddr==0 -> 0; else highest-index j with wen[j]&&waddr[j]==raddr -> wdata[j];
//   else rf[raddr]. Zero-cycle latency.
//  Write: rf[waddr[j]]<=wdata[j] on posedge when wen[j]&&waddr[j]!=0; same address on several ports ->
//   highest index stored. Writes to r0 dropped.
//  Scoreboard, per reg r!=0, next busy: flush ? 0 : (any set_en to r) ? 1 : (any wen to r) ? 0 : busy.
//   set wins over same-cycle clear (newer producer); flush wins over set. r0 never busy.
//  rbusy[i] = busy_q[raddr[i]] && !(any wen[j] to raddr[i]) && raddr[i]!=0; same-cycle sets not visible
//   until next cycle (issue logic resolves intra-bundle dependencies itself).
//  All address compares full AW bits; no X propagation from unused ports when enables are low.
// CONFIGURATION
//  MPRF_DBG_PORT_EN defined: adds ports dbg_addr in AW, dbg_data out DATA_W; dbg_data <= rf[dbg_addr]
//   registered, 1-cycle latency, no forwarding, reset value 0, reads 0 during INIT.
//  Undefined: ports absent, no extra flops; all other behaviour identical.
// STRUCTURE
//  mprf_pkg: AW function/localparam helper, typedef state_e {INIT,RUN}, typedefs reg_addr_t/reg_data_t
//   parametrised via package localparams DEF_DATA_W, DEF_NREG.
//  Sub-module mprf_scoreboard: busy vector, set/clear/flush logic, rbusy lookup with wen bypass.
//  Top holds array, init FSM, forwarding muxes, optional debug port.
// TESTING
//  Reset release -> init_done low exactly 31 cycles (NREG=32), then 1; all 31 regs read 0.
//  wen0 r5=0x11, wen1 r5=0x22 same cycle -> rdata for r5 = 0x22 same cycle; 0x22 next cycle from array.
//  wen1 r0=0xDEAD -> r0 reads 0, rbusy 0; set_en r0 -> rbusy stays 0.
//  set_en r7 -> next cycle rbusy=1; wen r7=0x55 -> same cycle rbusy=0, rdata=0x55; next cycle busy cleared.
//  set_en r9 and wen r9 same cycle -> r9 busy next cycle; flush with set_en r9 -> r9 not busy.
//  rst pulse mid-sweep at cnt=10 -> init restarts at 1, init_done after 31 further cycles.

Source files
------------

// File: rtl/mprf_pkg.sv
// -----------------------------------------------------------------------------
// mprf_pkg
// Shared types and defaults for the multi-port register file slice.
//   DEF_DATA_W / DEF_NREG : default register width and register count
//   addr_w()              : register address width for a given register count
//   state_e               : init-sweep FSM states (INIT, RUN)
//   reg_addr_t/reg_data_t : address/data types at the default sizes
// -----------------------------------------------------------------------------
package mprf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREG   = 32;

    function automatic int addr_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int DEF_AW = addr_w(DEF_NREG);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [DEF_AW-1:0]     reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/mprf_scoreboard.sv
// -----------------------------------------------------------------------------
// mprf_scoreboard
// One busy bit per architectural register, marking a pending producer.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (clears all busy bits)
//   run_i        : regfile is out of its init sweep; while low, busy is held 0
//   set_en_i/set_addr_i : issue-side destinations to mark busy
//   wen_i/waddr_i       : write-back commits that clear busy
//   flush_i      : clear every busy bit
//   raddr_i      : read addresses to look up
//   rbusy_o      : per-read-port busy, bypassed by a same-cycle write-back
// Next busy per register r != 0: flush ? 0 : set ? 1 : write ? 0 : hold.
// A same-cycle set is only visible on the following cycle.
// -----------------------------------------------------------------------------
module mprf_scoreboard
    import mprf_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 4,
    parameter int NWR  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run_i,
    input  logic [NWR-1:0]                set_en_i,
    input  logic [NWR*$clog2(NREG)-1:0]   set_addr_i,
    input  logic [NWR-1:0]                wen_i,
    input  logic [NWR*$clog2(NREG)-1:0]   waddr_i,
    input  logic                          flush_i,
    input  logic [NRD*$clog2(NREG)-1:0]   raddr_i,
    output logic [NRD-1:0]                rbusy_o
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            set_hit;
    logic            clr_hit;
    logic            rd_hit;
    logic [AW-1:0]   ra;

    always_comb begin
        busy_d  = busy_q;
        set_hit = 1'b0;
        clr_hit = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            set_hit = 1'b0;
            clr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (set_en_i[j] && (set_addr_i[j*AW +: AW] == AW'(r))) begin
                    set_hit = 1'b1;
                end
                if (wen_i[j] && (waddr_i[j*AW +: AW] == AW'(r))) begin
                    clr_hit = 1'b1;
                end
            end
            // newer producer (set) beats the retiring one (clear); flush beats all
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (set_hit) begin
                busy_d[r] = 1'b1;
            end else if (clr_hit) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        if (!run_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rbusy_o = '0;
        ra      = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra     = raddr_i[i*AW +: AW];
            rd_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wen_i[j] && (waddr_i[j*AW +: AW] == ra)) begin
                    rd_hit = 1'b1;
                end
            end
            // a write-back landing this cycle means the value is already available
            rbusy_o[i] = run_i && (ra != '0) && busy_q[ra] && !rd_hit;
        end
    end

endmodule

// File: rtl/mprf_regfile.sv
// -----------------------------------------------------------------------------
// mprf_regfile
// Multi-port GPR file with write-back forwarding, register scoreboard and a
// reset-time zeroing sweep. r0 reads as zero and is never busy.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   init_done  : 1 once the zeroing sweep has finished, until the next reset
//   raddr/rdata: NRD combinational read ports with forwarding from wdata
//   rbusy      : per-read-port scoreboard busy
//   wen/waddr/wdata : NWR write-back ports; higher index is the younger write
//   set_en/set_addr : NWR issue ports marking destinations busy
//   flush      : clear all busy bits
// Optional (MPRF_DBG_PORT_EN defined):
//   dbg_addr/dbg_data : registered 1-cycle array peek, no forwarding
//
// FSM states:
//   state | meaning
//   INIT  | zeroing rf[cnt], cnt 1..NREG-1; all inputs ignored, reads give 0
//   RUN   | normal operation
// -----------------------------------------------------------------------------
module mprf_regfile
    import mprf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          init_done,
    input  logic [NRD*$clog2(NREG)-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]         rdata,
    output logic [NRD-1:0]                rbusy,
    input  logic [NWR-1:0]                wen,
    input  logic [NWR*$clog2(NREG)-1:0]   waddr,
    input  logic [NWR*DATA_W-1:0]         wdata,
    input  logic [NWR-1:0]                set_en,
    input  logic [NWR*$clog2(NREG)-1:0]   set_addr,
    input  logic                          flush
`ifdef MPRF_DBG_PORT_EN
   ,input  logic [$clog2(NREG)-1:0]       dbg_addr
   ,output logic [DATA_W-1:0]             dbg_data
`endif
);

    localparam int            AW       = $clog2(NREG);
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          init_done_q;
    logic          run;

    logic [DATA_W-1:0] rf_q [NREG];

    logic [NWR-1:0] wen_eff;
    logic [NWR-1:0] set_eff;
    logic           flush_eff;

    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    // init sweep: rf[0] is never written since reads of r0 are forced to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            cnt_q       <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == LAST_REG) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign run       = (state_q == RUN);
    assign init_done = init_done_q;

    assign wen_eff   = run ? wen    : '0;
    assign set_eff   = run ? set_en : '0;
    assign flush_eff = run & flush;

    // array has no reset; the sweep zeroes it instead
    always_ff @(posedge clk) begin
        if (!run) begin
            rf_q[cnt_q] <= '0;
        end else begin
            // ascending loop: the highest-index port to an address is stored
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
                    rf_q[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            rd = '0;
            if (run && (ra != '0)) begin
                rd = rf_q[ra];
                // younger write port overrides older ones
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
                        rd = wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
            rdata[i*DATA_W +: DATA_W] = rd;
        end
    end

    mprf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .set_en_i   (set_eff),
        .set_addr_i (set_addr),
        .wen_i      (wen_eff),
        .waddr_i    (waddr),
        .flush_i    (flush_eff),
        .raddr_i    (raddr),
        .rbusy_o    (rbusy)
    );

`ifdef MPRF_DBG_PORT_EN
    logic [DATA_W-1:0] dbg_data_q;
    logic [DATA_W-1:0] dbg_data_d;

    always_comb begin
        dbg_data_d = '0;
        if (run && (dbg_addr != '0)) begin
            dbg_data_d = rf_q[dbg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_data_q <= '0;
        end else begin
            dbg_data_q <= dbg_data_d;
        end
    end

    assign dbg_data = dbg_data_q;
`endif

endmodule
